pixel_tick_ctrl: RTL and testbench

Programmable clock-enable controller for the display pipeline. Runs on the 100 MHz master clock and issues single-cycle `Tick_Out` enable pulses at a runtime-selectable divide ratio (default 4, i.e. 25 MHz pixel rate). It sequences start and stop on period boundaries and accepts divisor changes through a valid/ready handshake, so downstream logic never sees a short or split period.

---
 rtl/pixel_tick_ctrl_if.sv | 11 +
 rtl/pixel_tick_ctrl.sv | 57 +++++
 tb/tb_pixel_tick_ctrl.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pixel_tick_ctrl_if.sv
// pixel_tick_ctrl_if: divisor configuration handshake (master offers Cfg_Div on Cfg_Valid, slave answers Cfg_Ready / Cfg_Err)
interface pixel_tick_ctrl_if #(
  parameter int DIV_W = 8
);
  logic             Cfg_Valid;
  logic [DIV_W-1:0] Cfg_Div;
  logic             Cfg_Ready;
  logic             Cfg_Err;
  modport master (output Cfg_Valid, Cfg_Div, input Cfg_Ready, Cfg_Err);
  modport slave (input Cfg_Valid, Cfg_Div, output Cfg_Ready, Cfg_Err);
endinterface

// File: rtl/pixel_tick_ctrl.sv
// pixel_tick_ctrl: programmable tick divider; ports: Master_Clock_In/Reset_N clock and async active-low reset, Enable run request, cfg divisor handshake, Tick_Out period pulse, Running not-idle, Div_Out active divisor, Tick_Count ticks since reset
module pixel_tick_ctrl #(
  parameter int DIV_W       = 8,
  parameter int DIV_DEFAULT = 4,
  parameter int CNT_W       = 16
) (
  input  logic             Master_Clock_In,
  input  logic             Reset_N,
  input  logic             Enable,
  pixel_tick_ctrl_if.slave cfg,
  output logic             Tick_Out,
  output logic             Running,
  output logic [DIV_W-1:0] Div_Out,
  output logic [CNT_W-1:0] Tick_Count
);
  typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;
  state_t           state;
  logic [DIV_W-1:0] cnt, div, pend;
  logic             pend_v, err, acc, legal, wrap;
  assign acc           = cfg.Cfg_Valid && !pend_v;
  assign legal         = cfg.Cfg_Div >= DIV_W'(2);
  assign wrap          = state != IDLE && cnt == div - DIV_W'(1);
  assign cfg.Cfg_Ready = !pend_v;
  assign cfg.Cfg_Err   = err;
  assign Running       = state != IDLE;
  assign Div_Out       = div;
  always_ff @(posedge Master_Clock_In or negedge Reset_N)
    if (!Reset_N) begin
      state      <= IDLE;
      cnt        <= '0;
      div        <= DIV_W'(DIV_DEFAULT);
      pend       <= '0;
      pend_v     <= 1'b0;
      Tick_Out   <= 1'b0;
      err        <= 1'b0;
      Tick_Count <= '0;
    end else begin
      Tick_Out   <= wrap;
      err        <= acc && !legal;
      Tick_Count <= Tick_Count + CNT_W'(wrap);
      cnt        <= (state == IDLE || wrap) ? '0 : cnt + DIV_W'(1);
      // pend_v is clear whenever a transfer happens, so apply and accept never collide
      if (wrap && pend_v) begin
        div    <= pend;
        pend_v <= 1'b0;
      end
      if (acc && legal) begin
        if (state == IDLE) div <= cfg.Cfg_Div;
        else begin
          pend   <= cfg.Cfg_Div;
          pend_v <= 1'b1;
        end
      end
      // STOPPING finishes its period unless Enable returns first
      state <= Enable ? RUN : (state == IDLE || (state == STOPPING && wrap)) ? IDLE : STOPPING;
    end
endmodule

// File: tb/tb_pixel_tick_ctrl.sv
// tb_pixel_tick_ctrl: directed cycle-accurate scenarios plus randomized run against a behavioural model
module tb_pixel_tick_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        Tick_Out, Running;
  logic [7:0]  Div_Out;
  logic [15:0] Tick_Count;
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;

  pixel_tick_ctrl_if #(.DIV_W(8)) cfg ();

  pixel_tick_ctrl #(.DIV_W(8), .DIV_DEFAULT(4), .CNT_W(16)) dut (
    .Master_Clock_In(clk),
    .Reset_N(rst_n),
    .Enable(en),
    .cfg(cfg),
    .Tick_Out(Tick_Out),
    .Running(Running),
    .Div_Out(Div_Out),
    .Tick_Count(Tick_Count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en = 1'b0;
    cfg.Cfg_Valid = 1'b0;
    cfg.Cfg_Div = 8'd0;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    cyc = 0;
  endtask

  task automatic test_reset();
    logic [15:0] got[6];
    logic [15:0] expv[6];
    string       nm[6];
    do_reset();
    got = '{16'(Tick_Out), 16'(Running), 16'(Div_Out), Tick_Count, 16'(cfg.Cfg_Ready), 16'(cfg.Cfg_Err)};
    expv = '{16'd0, 16'd0, 16'd4, 16'd0, 16'd1, 16'd0};
    nm = '{"tick", "running", "div_out", "tick_count", "ready", "err"};
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (got[i] !== expv[i]) begin failures++; $display("FAIL reset_%s got=%0d exp=%0d", nm[i], got[i], expv[i]); end
    end
  endtask

  task automatic test_default_run();
    bit t;
    do_reset();
    en = 1'b1;
    repeat (20) begin
      step();
      t = cyc >= 5 && (cyc - 5) % 4 == 0;
      checks++; if (Tick_Out !== t) begin failures++; $display("FAIL default_tick cyc=%0d got=%0b exp=%0b", cyc, Tick_Out, t); end
      checks++; if (Running !== 1'b1) begin failures++; $display("FAIL default_running cyc=%0d got=%0b exp=1", cyc, Running); end
      if (cyc == 17) begin
        checks++; if (Tick_Count !== 16'd4) begin failures++; $display("FAIL default_count got=%0d exp=4", Tick_Count); end
        checks++; if (Div_Out !== 8'd4) begin failures++; $display("FAIL default_div got=%0d exp=4", Div_Out); end
      end
    end
    en = 1'b0;
  endtask

  task automatic test_reconfig();
    bit t, r;
    int d;
    do_reset();
    en = 1'b1;
    repeat (22) begin
      step();
      t = cyc inside {5, 9, 15, 21};
      r = !(cyc inside {7, 8});
      d = cyc >= 9 ? 6 : 4;
      checks++; if (Tick_Out !== t) begin failures++; $display("FAIL reconfig_tick cyc=%0d got=%0b exp=%0b", cyc, Tick_Out, t); end
      checks++; if (cfg.Cfg_Ready !== r) begin failures++; $display("FAIL reconfig_ready cyc=%0d got=%0b exp=%0b", cyc, cfg.Cfg_Ready, r); end
      checks++; if (Div_Out !== 8'(d)) begin failures++; $display("FAIL reconfig_div cyc=%0d got=%0d exp=%0d", cyc, Div_Out, d); end
      cfg.Cfg_Valid = cyc == 6;
      cfg.Cfg_Div = 8'd6;
    end
    cfg.Cfg_Valid = 1'b0;
    en = 1'b0;
  endtask

  task automatic test_back_pressure();
    bit t, r;
    int d;
    do_reset();
    en = 1'b1;
    repeat (22) begin
      step();
      t = cyc inside {5, 9, 15, 18, 21};
      r = !(cyc inside {[7:8], [10:14]});
      d = cyc >= 15 ? 3 : cyc >= 9 ? 6 : 4;
      checks++; if (Tick_Out !== t) begin failures++; $display("FAIL backp_tick cyc=%0d got=%0b exp=%0b", cyc, Tick_Out, t); end
      checks++; if (cfg.Cfg_Ready !== r) begin failures++; $display("FAIL backp_ready cyc=%0d got=%0b exp=%0b", cyc, cfg.Cfg_Ready, r); end
      checks++; if (Div_Out !== 8'(d)) begin failures++; $display("FAIL backp_div cyc=%0d got=%0d exp=%0d", cyc, Div_Out, d); end
      cfg.Cfg_Valid = cyc inside {[6:9]};
      cfg.Cfg_Div = cyc == 6 ? 8'd6 : 8'd3;
    end
    cfg.Cfg_Valid = 1'b0;
    en = 1'b0;
  endtask

  task automatic test_illegal();
    bit t, e;
    do_reset();
    cfg.Cfg_Valid = 1'b1;
    cfg.Cfg_Div = 8'd1;
    step();
    checks++; if (cfg.Cfg_Err !== 1'b1) begin failures++; $display("FAIL illegal_idle_err got=%0b exp=1", cfg.Cfg_Err); end
    checks++; if (Div_Out !== 8'd4) begin failures++; $display("FAIL illegal_idle_div got=%0d exp=4", Div_Out); end
    checks++; if (cfg.Cfg_Ready !== 1'b1) begin failures++; $display("FAIL illegal_idle_ready got=%0b exp=1", cfg.Cfg_Ready); end
    checks++; if (Running !== 1'b0) begin failures++; $display("FAIL illegal_idle_running got=%0b exp=0", Running); end
    cfg.Cfg_Valid = 1'b0;
    step();
    checks++; if (cfg.Cfg_Err !== 1'b0) begin failures++; $display("FAIL illegal_idle_err_width got=%0b exp=0", cfg.Cfg_Err); end
    en = 1'b1;
    cyc = 0;
    repeat (18) begin
      step();
      t = cyc inside {5, 9, 13, 17};
      e = cyc == 7;
      checks++; if (Tick_Out !== t) begin failures++; $display("FAIL illegal_run_tick cyc=%0d got=%0b exp=%0b", cyc, Tick_Out, t); end
      checks++; if (cfg.Cfg_Err !== e) begin failures++; $display("FAIL illegal_run_err cyc=%0d got=%0b exp=%0b", cyc, cfg.Cfg_Err, e); end
      checks++; if (Div_Out !== 8'd4) begin failures++; $display("FAIL illegal_run_div cyc=%0d got=%0d exp=4", cyc, Div_Out); end
      checks++; if (cfg.Cfg_Ready !== 1'b1) begin failures++; $display("FAIL illegal_run_ready cyc=%0d got=%0b exp=1", cyc, cfg.Cfg_Ready); end
      cfg.Cfg_Valid = cyc == 6;
      cfg.Cfg_Div = 8'd0;
    end
    cfg.Cfg_Valid = 1'b0;
    en = 1'b0;
  endtask

  task automatic test_stop();
    bit t, r;
    do_reset();
    en = 1'b1;
    repeat (16) begin
      step();
      t = cyc inside {5, 9};
      r = cyc inside {[1:8]};
      checks++; if (Tick_Out !== t) begin failures++; $display("FAIL stop_tick cyc=%0d got=%0b exp=%0b", cyc, Tick_Out, t); end
      checks++; if (Running !== r) begin failures++; $display("FAIL stop_running cyc=%0d got=%0b exp=%0b", cyc, Running, r); end
      if (cyc == 6) en = 1'b0;
    end
    checks++; if (Tick_Count !== 16'd2) begin failures++; $display("FAIL stop_count got=%0d exp=2", Tick_Count); end
  endtask

  task automatic test_restart();
    bit t;
    do_reset();
    en = 1'b1;
    repeat (18) begin
      step();
      t = cyc inside {5, 9, 13, 17};
      checks++; if (Tick_Out !== t) begin failures++; $display("FAIL restart_tick cyc=%0d got=%0b exp=%0b", cyc, Tick_Out, t); end
      checks++; if (Running !== 1'b1) begin failures++; $display("FAIL restart_running cyc=%0d got=%0b exp=1", cyc, Running); end
      en = cyc != 6;
    end
    en = 1'b0;
  endtask

  task automatic test_async_reset();
    bit t;
    do_reset();
    en = 1'b1;
    repeat (7) begin
      step();
      cfg.Cfg_Valid = cyc == 6;
      cfg.Cfg_Div = 8'd6;
    end
    checks++; if (cfg.Cfg_Ready !== 1'b0) begin failures++; $display("FAIL arst_pre_ready got=%0b exp=0", cfg.Cfg_Ready); end
    checks++; if (Tick_Count !== 16'd1) begin failures++; $display("FAIL arst_pre_count got=%0d exp=1", Tick_Count); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (Running !== 1'b0) begin failures++; $display("FAIL arst_running got=%0b exp=0", Running); end
    checks++; if (Tick_Count !== 16'd0) begin failures++; $display("FAIL arst_count got=%0d exp=0", Tick_Count); end
    checks++; if (cfg.Cfg_Ready !== 1'b1) begin failures++; $display("FAIL arst_ready got=%0b exp=1", cfg.Cfg_Ready); end
    checks++; if (Div_Out !== 8'd4) begin failures++; $display("FAIL arst_div got=%0d exp=4", Div_Out); end
    checks++; if (Tick_Out !== 1'b0) begin failures++; $display("FAIL arst_tick got=%0b exp=0", Tick_Out); end
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    cyc = 0;
    repeat (10) begin
      step();
      t = cyc inside {5, 9};
      checks++; if (Tick_Out !== t) begin failures++; $display("FAIL arst_restart_tick cyc=%0d got=%0b exp=%0b", cyc, Tick_Out, t); end
      checks++; if (Div_Out !== 8'd4) begin failures++; $display("FAIL arst_restart_div cyc=%0d got=%0d exp=4", cyc, Div_Out); end
      if (cyc == 5) begin
        checks++; if (Tick_Count !== 16'd1) begin failures++; $display("FAIL arst_restart_count got=%0d exp=1", Tick_Count); end
      end
    end
    en = 1'b0;
  endtask

  // Reference: a run is a sequence of whole periods; a stop request is honoured only when a period completes
  task automatic test_random();
    bit          act = 0, stopping = 0, tk = 0, er = 0, acc, legal, done;
    int          phase = 0, mdiv = 4, mpend = -1;
    logic [15:0] mcnt = 0;
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 7) == 0) en = ~en;
      cfg.Cfg_Valid = $urandom_range(0, 3) == 0;
      cfg.Cfg_Div = 8'($urandom_range(0, 9));
      @(posedge clk);
      acc = cfg.Cfg_Valid && mpend < 0;
      legal = cfg.Cfg_Div >= 2;
      done = act && phase + 1 == mdiv;
      tk = done;
      er = acc && !legal;
      mcnt = mcnt + 16'(done);
      if (!act) begin
        if (acc && legal) mdiv = int'(cfg.Cfg_Div);
        if (en) begin act = 1; stopping = 0; phase = 0; end
      end else begin
        phase = done ? 0 : phase + 1;
        if (done && mpend >= 0) begin mdiv = mpend; mpend = -1; end
        if (acc && legal) mpend = int'(cfg.Cfg_Div);
        if (en) stopping = 0;
        else if (stopping && done) act = 0;
        else stopping = 1;
      end
      #1;
      checks++; if (Tick_Out !== tk) begin failures++; $display("FAIL rand_tick i=%0d got=%0b exp=%0b", i, Tick_Out, tk); end
      checks++; if (Running !== act) begin failures++; $display("FAIL rand_running i=%0d got=%0b exp=%0b", i, Running, act); end
      checks++; if (Div_Out !== 8'(mdiv)) begin failures++; $display("FAIL rand_div i=%0d got=%0d exp=%0d", i, Div_Out, mdiv); end
      checks++; if (Tick_Count !== mcnt) begin failures++; $display("FAIL rand_count i=%0d got=%0d exp=%0d", i, Tick_Count, mcnt); end
      checks++; if (cfg.Cfg_Ready !== (mpend < 0)) begin failures++; $display("FAIL rand_ready i=%0d got=%0b exp=%0b", i, cfg.Cfg_Ready, mpend < 0); end
      checks++; if (cfg.Cfg_Err !== er) begin failures++; $display("FAIL rand_err i=%0d got=%0b exp=%0b", i, cfg.Cfg_Err, er); end
    end
    cfg.Cfg_Valid = 1'b0;
    en = 1'b0;
  endtask

  initial begin
    cfg.Cfg_Valid = 1'b0;
    cfg.Cfg_Div = 8'd0;
    test_reset();
    test_default_run();
    test_reconfig();
    test_back_pressure();
    test_illegal();
    test_stop();
    test_restart();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
